// File: rtl/ib_lut_ram_loader.sv
// ib_lut_ram_loader: packs QUAN_SIZE-bit LUT entries into ROM words and writes them to IB RAM port A.
// Define IB_LOADER_READBACK_EN to add a port-B read-back XOR check after the last write.
module ib_lut_ram_loader #(
   parameter int QUAN_SIZE      = 4,
   parameter int ENTRY_PER_WORD = 9,
   parameter int ROM_WORD_WIDTH = 36,
   parameter int ADDR_WIDTH     = 11,
   parameter int WORD_NUM       = 114
) (
   input  logic                      sys_clk,
   input  logic                      rstn,
   input  logic                      load_start,
   input  logic [QUAN_SIZE-1:0]      lut_in_data,
   input  logic                      lut_in_valid,
   output logic                      lut_in_ready,
   output logic [ADDR_WIDTH-1:0]     ram_addrA,
   output logic [ROM_WORD_WIDTH-1:0] ram_dinA,
   output logic                      ram_weA,
   output logic [ADDR_WIDTH-1:0]     ram_addrB,
   input  logic [ROM_WORD_WIDTH-1:0] ram_doutB,
   output logic                      busy,
   output logic                      load_done,
   output logic                      verify_err
);
   localparam int EW = $clog2(ENTRY_PER_WORD);
   localparam logic [EW-1:0]         LAST_ENTRY = EW'(ENTRY_PER_WORD - 1);
   localparam logic [EW-1:0]         ENT_ONE    = EW'(1);
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = ADDR_WIDTH'(WORD_NUM - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, VERIFY = 2'd2, DONE = 2'd3} state_t;

   state_t                    state_q, state_d;
   logic                      ready_q, ready_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      we_q, we_d;
   logic [ADDR_WIDTH-1:0]     addra_q, addra_d;
   logic [ROM_WORD_WIDTH-1:0] dina_q, dina_d;
   logic [ROM_WORD_WIDTH-1:0] pack_q, pack_d;
   logic [EW-1:0]             entry_cnt_q, entry_cnt_d;
   logic [ADDR_WIDTH-1:0]     word_cnt_q, word_cnt_d;
   logic [ROM_WORD_WIDTH-1:0] csum_q, csum_d;
   logic [ROM_WORD_WIDTH-1:0] word_s;
`ifdef IB_LOADER_READBACK_EN
   logic [ADDR_WIDTH-1:0]     addrb_q, addrb_d;
   logic                      issue_q, issue_d;
   logic                      issue_last_q, issue_last_d;
   logic                      dvld_q, dvld_d;
   logic                      dlast_q, dlast_d;
   logic [ROM_WORD_WIDTH-1:0] acc_q, acc_d;
   logic                      verr_q, verr_d;
`endif

   // Next-state, packing and write/verify control.
   always_comb begin
      state_d     = state_q;
      ready_d     = ready_q;
      busy_d      = busy_q;
      done_d      = done_q;
      we_d        = 1'b0;
      addra_d     = addra_q;
      dina_d      = dina_q;
      pack_d      = pack_q;
      entry_cnt_d = entry_cnt_q;
      word_cnt_d  = word_cnt_q;
      csum_d      = csum_q;
      word_s      = pack_q;
      word_s[QUAN_SIZE*int'(entry_cnt_q) +: QUAN_SIZE] = lut_in_data;
`ifdef IB_LOADER_READBACK_EN
      addrb_d      = addrb_q;
      issue_d      = 1'b0;
      issue_last_d = issue_last_q;
      dvld_d       = 1'b0;
      dlast_d      = 1'b0;
      acc_d        = acc_q;
      verr_d       = verr_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (load_start) begin
               state_d     = LOAD;
               ready_d     = 1'b1;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               entry_cnt_d = '0;
               word_cnt_d  = '0;
               csum_d      = '0;
`ifdef IB_LOADER_READBACK_EN
               verr_d = 1'b0;
               acc_d  = '0;
`endif
            end else begin
               state_d = state_q;
            end
         end
         LOAD: begin
            if (lut_in_valid && ready_q) begin
               pack_d = word_s;
               if (entry_cnt_q == LAST_ENTRY) begin
                  entry_cnt_d = '0;
                  we_d        = 1'b1;
                  addra_d     = word_cnt_q;
                  dina_d      = word_s;
                  word_cnt_d  = word_cnt_q + ADDR_ONE;
                  csum_d      = csum_q ^ word_s;
                  if (word_cnt_q == LAST_WORD) begin
                     ready_d = 1'b0;
`ifdef IB_LOADER_READBACK_EN
                     state_d      = VERIFY;
                     addrb_d      = '0;
                     issue_d      = 1'b1;
                     issue_last_d = (LAST_WORD == '0);
`else
                     state_d = DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
`endif
                  end else begin
                     state_d = LOAD;
                  end
               end else begin
                  entry_cnt_d = entry_cnt_q + ENT_ONE;
               end
            end else begin
               state_d = LOAD;
            end
         end
         VERIFY: begin
`ifdef IB_LOADER_READBACK_EN
            // Data for an issued address arrives one cycle later, hence the dvld/dlast delay stage.
            dvld_d  = issue_q;
            dlast_d = issue_q & issue_last_q;
            if (issue_q && !issue_last_q) begin
               issue_d      = 1'b1;
               addrb_d      = addrb_q + ADDR_ONE;
               issue_last_d = ((addrb_q + ADDR_ONE) == LAST_WORD);
            end else begin
               issue_d = 1'b0;
            end
            if (dvld_q) begin
               acc_d = acc_q ^ ram_doutB;
               if (dlast_q) begin
                  verr_d  = ((acc_q ^ ram_doutB) != csum_q);
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = VERIFY;
               end
            end else begin
               state_d = VERIFY;
            end
`else
            state_d = IDLE;
            busy_d  = 1'b0;
`endif
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge sys_clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         we_q        <= 1'b0;
         addra_q     <= '0;
         dina_q      <= '0;
         pack_q      <= '0;
         entry_cnt_q <= '0;
         word_cnt_q  <= '0;
         csum_q      <= '0;
`ifdef IB_LOADER_READBACK_EN
         addrb_q      <= '0;
         issue_q      <= 1'b0;
         issue_last_q <= 1'b0;
         dvld_q       <= 1'b0;
         dlast_q      <= 1'b0;
         acc_q        <= '0;
         verr_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         we_q        <= we_d;
         addra_q     <= addra_d;
         dina_q      <= dina_d;
         pack_q      <= pack_d;
         entry_cnt_q <= entry_cnt_d;
         word_cnt_q  <= word_cnt_d;
         csum_q      <= csum_d;
`ifdef IB_LOADER_READBACK_EN
         addrb_q      <= addrb_d;
         issue_q      <= issue_d;
         issue_last_q <= issue_last_d;
         dvld_q       <= dvld_d;
         dlast_q      <= dlast_d;
         acc_q        <= acc_d;
         verr_q       <= verr_d;
`endif
      end
   end

   assign lut_in_ready = ready_q;
   assign ram_weA      = we_q;
   assign ram_addrA    = addra_q;
   assign ram_dinA     = dina_q;
   assign busy         = busy_q;
   assign load_done    = done_q;
`ifdef IB_LOADER_READBACK_EN
   assign ram_addrB  = addrb_q;
   assign verify_err = verr_q;
`else
   logic unused_doutb_s;
   assign unused_doutb_s = ^ram_doutB;
   assign ram_addrB      = '0;
   assign verify_err     = 1'b0;
`endif
endmodule

// File: tb/tb_ib_lut_ram_loader.sv
// Randomised bench for ib_lut_ram_loader: a transaction-level model predicts every output each cycle,
// plus literal checks on reset, the first packed word, pulse counts and the resulting RAM image.
`timescale 1ns/1ps
module tb_ib_lut_ram_loader;
   localparam int QS = 4, EPW = 9, RW = 36, AW = 11, WN = 114, NENT = EPW * WN;

   logic clk = 1'b0;
   logic rstn, load_start, lut_in_valid, lut_in_ready, ram_weA, busy, load_done, verify_err;
   logic [QS-1:0] lut_in_data;
   logic [AW-1:0] ram_addrA, ram_addrB;
   logic [RW-1:0] ram_dinA, ram_doutB;

   always #5 clk = ~clk;

   ib_lut_ram_loader dut (
      .sys_clk(clk), .rstn(rstn), .load_start(load_start),
      .lut_in_data(lut_in_data), .lut_in_valid(lut_in_valid), .lut_in_ready(lut_in_ready),
      .ram_addrA(ram_addrA), .ram_dinA(ram_dinA), .ram_weA(ram_weA),
      .ram_addrB(ram_addrB), .ram_doutB(ram_doutB),
      .busy(busy), .load_done(load_done), .verify_err(verify_err)
   );

   // Dual-port RAM model; optionally flips bit 0 of word 7 on write.
   logic [RW-1:0] mem [0:(1<<AW)-1];
   logic clr_mem = 1'b0, corrupt = 1'b0;
   always @(posedge clk) begin
      if (clr_mem) begin
         for (int a = 0; a < (1 << AW); a++) mem[a] <= '0;
      end else if (ram_weA) begin
         mem[ram_addrA] <= (corrupt && ram_addrA == 11'd7) ? (ram_dinA ^ 36'd1) : ram_dinA;
      end
      ram_doutB <= mem[ram_addrB];
   end

   int n_vec = 0, n_err = 0;
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: counts accepted entries, emits a word every EPW accepts.
   bit m_load, m_ver, m_ready, m_we, m_busy, m_done, m_verr;
   logic [AW-1:0] m_addra, m_addrb;
   logic [RW-1:0] m_dina;
   logic [QS-1:0] m_buf [0:EPW-1];
   int m_k, m_w, m_vcnt, m_cyc = 0;

   always @(posedge clk) begin : model
      m_cyc++;
      if (!rstn) begin
         m_load = 0; m_ver = 0; m_ready = 0; m_we = 0; m_busy = 0; m_done = 0; m_verr = 0;
         m_addra = '0; m_addrb = '0; m_dina = '0; m_k = 0; m_w = 0; m_vcnt = 0;
      end else begin
         m_we = 0;
         if (m_load) begin
            if (lut_in_valid && m_ready) begin
               m_buf[m_k] = lut_in_data;
               m_k++;
               if (m_k == EPW) begin
                  m_k = 0; m_we = 1; m_addra = AW'(m_w);
                  for (int j = 0; j < EPW; j++) m_dina[QS*j +: QS] = m_buf[j];
                  m_w++;
                  if (m_w == WN) begin
                     m_load = 0; m_ready = 0;
`ifdef IB_LOADER_READBACK_EN
                     m_ver = 1; m_vcnt = 0; m_addrb = '0;
`else
                     m_busy = 0; m_done = 1;
`endif
                  end
               end
            end
         end else if (m_ver) begin
            m_vcnt++;
            if (m_vcnt < WN) m_addrb = AW'(m_vcnt);
            if (m_vcnt == WN + 1) begin
               m_ver = 0; m_busy = 0; m_done = 1; m_verr = corrupt;
            end
         end else if (load_start) begin
            m_load = 1; m_ready = 1; m_busy = 1; m_done = 0; m_verr = 0; m_k = 0; m_w = 0;
         end
      end
   end

   // Per-cycle compare against the model, plus a log of write pulses.
   int pcnt = 0;
   logic [AW-1:0] p_addr [0:1023];
   logic [RW-1:0] p_din  [0:1023];
   int p_cyc [0:1023];
   always @(negedge clk) begin : compare
      if (m_cyc > 0) begin
         check("ready", lut_in_ready, m_ready);
         check("weA", ram_weA, m_we);
         check("addrA", ram_addrA, m_addra);
         check("dinA", ram_dinA, m_dina);
         check("busy", busy, m_busy);
         check("load_done", load_done, m_done);
         check("verify_err", verify_err, m_verr);
         check("addrB", ram_addrB, m_addrb);
         if (ram_weA) begin
            if (pcnt < 1024) begin
               p_addr[pcnt] = ram_addrA; p_din[pcnt] = ram_dinA; p_cyc[pcnt] = m_cyc;
            end
            pcnt++;
         end
      end
   end

   logic [QS-1:0] stream [0:NENT-1];
   logic [RW-1:0] img [0:WN-1];
   int base;

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0; load_start = 1'b0; lut_in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic start_load();
      @(negedge clk);
      load_start = 1'b1; lut_in_valid = 1'b0;
   endtask

   task automatic feed(input bit gaps, input bit extra, input int n);
      int i = 0, budget = 0;
      bit pend = 0;
      while (i < n && budget < 20000) begin
         @(negedge clk);
         if (pend) i++;
         pend = 0;
         load_start = extra && (i < n - 10) && ($urandom_range(0, 39) == 0);
         if (i < n) begin
            lut_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            lut_in_data  = stream[i];
            pend = lut_in_valid && lut_in_ready;
         end else begin
            lut_in_valid = 1'b0;
         end
         budget++;
      end
      check("feed_accepts", i, n);
   endtask

   task automatic wait_done();
      int t = 0;
      while (!load_done && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("done_reached", load_done, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_load(input string tag);
      check({tag, "_pulses"}, pcnt - base, WN);
      check({tag, "_first_addr"}, p_addr[base], 0);
      check({tag, "_last_addr"}, p_addr[base+WN-1], WN - 1);
      for (int a = 0; a < WN; a++) check({tag, "_image"}, mem[a], img[a]);
   endtask

   initial begin
      rstn = 1'b0; load_start = 1'b0; lut_in_valid = 1'b0; lut_in_data = '0;
      clr_mem = 1'b1;
      repeat (2) @(negedge clk);
      clr_mem = 1'b0;
      check("rst_ready", lut_in_ready, 0);
      check("rst_weA", ram_weA, 0);
      check("rst_busy", busy, 0);
      check("rst_done", load_done, 0);
      check("rst_verr", verify_err, 0);
      rstn = 1'b1;

      // First word from entries 0..8.
      for (int k = 0; k < EPW; k++) stream[k] = QS'(k);
      base = pcnt;
      start_load();
      feed(1'b0, 1'b0, EPW);
      repeat (3) @(negedge clk);
      check("s2_pulses", pcnt - base, 1);
      check("s2_addr", p_addr[base], 0);
      check("s2_din", p_din[base], 36'h876543210);
      do_reset();

      // Full back-to-back load of a random stream.
      for (int k = 0; k < NENT; k++) stream[k] = QS'($urandom);
      for (int a = 0; a < WN; a++)
         for (int j = 0; j < EPW; j++) img[a][QS*j +: QS] = stream[a*EPW + j];
      base = pcnt;
      start_load();
      feed(1'b0, 1'b0, NENT);
      wait_done();
      check_load("s3");
      check("s3_span", p_cyc[base+WN-1] - p_cyc[base], (WN - 1) * EPW);
      check("s3_verr", verify_err, 0);

      // Same stream with valid gaps and stray load_start pulses.
      @(negedge clk); clr_mem = 1'b1;
      @(negedge clk); clr_mem = 1'b0;
      base = pcnt;
      start_load();
      feed(1'b1, 1'b1, NENT);
      wait_done();
      check_load("s4");

      // Abort after word 50, then reload from address 0.
      base = pcnt;
      start_load();
      feed(1'b0, 1'b0, 51 * EPW);
      repeat (2) @(negedge clk);
      check("s5_partial", pcnt - base, 51);
      do_reset();
      base = pcnt;
      start_load();
      feed(1'b1, 1'b0, NENT);
      wait_done();
      check_load("s5");

`ifdef IB_LOADER_READBACK_EN
      // Corrupted word 7 must be flagged, load still completes.
      corrupt = 1'b1;
      base = pcnt;
      start_load();
      feed(1'b0, 1'b0, NENT);
      wait_done();
      check("s6_verr", verify_err, 1);
      check("s6_done", load_done, 1);
      corrupt = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
